sram_byte_bridge: RTL

Parametrised bridge between the core's byte-wide SRAM interface (separate write and read ports) and a bank array of 32-bit x 256-word dual-port SRAM macros (port 0 write, port 1 read). It generalises the fixed single-1 kB-macro hookup to any power-of-two memory size, with the bank count derived from `MEMSIZE`. It adds three behaviours:

- a write-combining buffer that merges byte writes to the same word into one masked word write;
- a registered read-data path with byte and bank select;
- read forwarding from pending and in-flight writes.

---
 rtl/sram_byte_bridge.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_byte_bridge.sv
// sram_byte_bridge
//
// Bridges a byte-wide core SRAM interface (independent write and read
// ports) onto an array of 32-bit x 256-word dual-port SRAM macros
// (port 0 write-only, port 1 read-only), one macro per 1 kB bank.
//
// Byte writes to the same word are gathered in a write-combining buffer
// and committed as a single masked word write. Reads are served with a
// fixed two-cycle latency. The returned byte comes from the write buffer
// or the in-flight port-0 write when either holds a newer copy than the
// macro.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_waddr/i_wdata     byte write address / data, strobed by i_wen
//   i_raddr/i_ren       byte read address / strobe
//   o_rdata/o_rvalid    read byte, valid for one cycle
//   i_flush             force the pending buffer to commit
//   o_pending           write buffer holds uncommitted data
//   o_mem_csb0          port-0 chip selects (active-low, one per bank)
//   o_mem_wmask0        port-0 byte write mask
//   o_mem_addr0         port-0 word address
//   o_mem_din0          port-0 write data
//   o_mem_csb1          port-1 chip selects (active-low, one per bank)
//   o_mem_addr1         port-1 word address
//   i_mem_dout1         port-1 read data, bank b at [b*32 +: 32]
module sram_byte_bridge #(
    parameter int MEMSIZE    = 8192,
    parameter int IDLE_FLUSH = 4,
    localparam int AW        = $clog2(MEMSIZE),
    localparam int NBANKS    = MEMSIZE / 1024,
    localparam int WAW       = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [AW-1:0]          i_waddr,
    input  logic [7:0]             i_wdata,
    input  logic                   i_wen,
    input  logic [AW-1:0]          i_raddr,
    input  logic                   i_ren,
    output logic [7:0]             o_rdata,
    output logic                   o_rvalid,
    input  logic                   i_flush,
    output logic                   o_pending,
    output logic [NBANKS-1:0]      o_mem_csb0,
    output logic [3:0]             o_mem_wmask0,
    output logic [WAW-1:0]         o_mem_addr0,
    output logic [31:0]            o_mem_din0,
    output logic [NBANKS-1:0]      o_mem_csb1,
    output logic [WAW-1:0]         o_mem_addr1,
    input  logic [NBANKS*32-1:0]   i_mem_dout1
);

    // Bank index width; a single-bank build keeps a 1-bit index tied to 0.
    localparam int BW = (NBANKS > 1) ? AW - 10 : 1;
    localparam logic [3:0] IDLE_LAST = 4'(IDLE_FLUSH - 1);

    // Write-combining buffer state
    logic                buf_valid;
    logic [AW-3:0]       buf_waddr;
    logic [31:0]         buf_data;
    logic [3:0]          buf_mask;
    logic [3:0]          idle_cnt;

    logic                buf_valid_d;
    logic [AW-3:0]       buf_waddr_d;
    logic [31:0]         buf_data_d;
    logic [3:0]          buf_mask_d;
    logic [3:0]          idle_cnt_d;
    logic                commit;

    // Address decode helpers
    logic [BW-1:0]       buf_bank;
    logic [BW-1:0]       rd_bank;
    logic [NBANKS-1:0]   buf_onehot;
    logic [NBANKS-1:0]   rd_onehot;
    logic [1:0]          wr_lane;
    logic [1:0]          rd_lane;
    logic [3:0]          wr_lane_bit;
    logic [31:0]         wr_placed;
    logic [31:0]         wr_keep;
    logic                same_word;

    // Read pipeline
    logic                rd_pend;
    logic [1:0]          rd_lane_q;
    logic [BW-1:0]       rd_bank_q;
    logic                fwd_hit_q;
    logic [7:0]          fwd_byte_q;
    logic                buf_hit;
    logic                fly_hit;
    logic [7:0]          fwd_byte_d;
    logic [31:0]         macro_word;
    logic [7:0]          macro_byte;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    generate
        if (NBANKS > 1) begin : g_bank
            assign buf_bank = buf_waddr[AW-3:8];
            assign rd_bank  = i_raddr[AW-1:10];
        end else begin : g_nobank
            assign buf_bank = '0;
            assign rd_bank  = '0;
        end
    endgenerate

    assign wr_lane     = i_waddr[1:0];
    assign rd_lane     = i_raddr[1:0];
    assign wr_lane_bit = 4'b0001 << wr_lane;
    assign wr_placed   = {24'h0, i_wdata} << {wr_lane, 3'b000};
    assign wr_keep     = ~(32'h0000_00FF << {wr_lane, 3'b000});
    assign same_word   = (i_waddr[AW-1:2] == buf_waddr);
    assign o_pending   = buf_valid;

    // Bank one-hot decodes for the buffered word and the read address.
    always_comb begin
        buf_onehot = '0;
        rd_onehot  = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (BW'(b) == buf_bank) buf_onehot[b] = 1'b1;
            if (BW'(b) == rd_bank)  rd_onehot[b]  = 1'b1;
        end
    end

    // Next buffer state. A write to a different word evicts the current
    // contents as a commit and starts a fresh buffer in the same edge.
    // Without a write, a full, flushed or timed-out buffer commits.
    always_comb begin
        buf_valid_d = buf_valid;
        buf_waddr_d = buf_waddr;
        buf_data_d  = buf_data;
        buf_mask_d  = buf_mask;
        idle_cnt_d  = idle_cnt;
        commit      = 1'b0;
        if (i_wen) begin
            if (!buf_valid || !same_word) begin
                commit      = buf_valid;
                buf_valid_d = 1'b1;
                buf_waddr_d = i_waddr[AW-1:2];
                buf_data_d  = wr_placed;
                buf_mask_d  = wr_lane_bit;
            end else begin
                buf_data_d  = (buf_data & wr_keep) | wr_placed;
                buf_mask_d  = buf_mask | wr_lane_bit;
            end
            idle_cnt_d = 4'd0;
        end else if (buf_valid) begin
            if (i_flush || (buf_mask == 4'hF) || (idle_cnt == IDLE_LAST)) begin
                commit      = 1'b1;
                buf_valid_d = 1'b0;
                buf_data_d  = '0;
                buf_mask_d  = '0;
                idle_cnt_d  = 4'd0;
            end else begin
                idle_cnt_d  = idle_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_valid <= 1'b0;
            buf_waddr <= '0;
            buf_data  <= '0;
            buf_mask  <= '0;
            idle_cnt  <= '0;
        end else begin
            buf_valid <= buf_valid_d;
            buf_waddr <= buf_waddr_d;
            buf_data  <= buf_data_d;
            buf_mask  <= buf_mask_d;
            idle_cnt  <= idle_cnt_d;
        end
    end

    // Port-0 registers: a commit drives one cycle of chip select for the
    // buffer's bank. Lanes outside the mask are always zero in buf_data.
    // Mask/address/data hold after the pulse so the in-flight forwarding
    // compare only needs to look at the chip select.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_csb0   <= '1;
            o_mem_wmask0 <= '0;
            o_mem_addr0  <= '0;
            o_mem_din0   <= '0;
        end else if (commit) begin
            o_mem_csb0   <= ~buf_onehot;
            o_mem_wmask0 <= buf_mask;
            o_mem_addr0  <= buf_waddr[WAW-1:0];
            o_mem_din0   <= buf_data;
        end else begin
            o_mem_csb0   <= '1;
        end
    end

    assign o_mem_csb1  = i_ren ? ~rd_onehot : '1;
    assign o_mem_addr1 = i_raddr[9:2];

    // Forwarding snapshot at the request edge. The buffer is the newest
    // copy, the port-0 register is written into the macro on this very
    // edge and so is invisible to the macro read.
    always_comb begin
        buf_hit    = buf_valid && (buf_waddr == i_raddr[AW-1:2]) && buf_mask[rd_lane];
        fly_hit    = (|(~o_mem_csb0 & rd_onehot)) && (o_mem_addr0 == i_raddr[9:2])
                     && o_mem_wmask0[rd_lane];
        fwd_byte_d = buf_hit ? lane_byte(buf_data, rd_lane) : lane_byte(o_mem_din0, rd_lane);
    end

    always_comb begin
        macro_word = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (BW'(b) == rd_bank_q) macro_word = i_mem_dout1[b*32 +: 32];
        end
        macro_byte = lane_byte(macro_word, rd_lane_q);
    end

    // Two-stage read pipeline: request snapshot, then registered output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_pend    <= 1'b0;
            rd_lane_q  <= '0;
            rd_bank_q  <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_byte_q <= '0;
            o_rvalid   <= 1'b0;
            o_rdata    <= '0;
        end else begin
            rd_pend  <= i_ren;
            o_rvalid <= rd_pend;
            if (i_ren) begin
                rd_lane_q  <= rd_lane;
                rd_bank_q  <= rd_bank;
                fwd_hit_q  <= buf_hit || fly_hit;
                fwd_byte_q <= fwd_byte_d;
            end
            if (rd_pend) begin
                o_rdata <= fwd_hit_q ? fwd_byte_q : macro_byte;
            end
        end
    end

endmodule
